// File: rtl/pulse_train_gen.sv
// Counted pulse-train generator: programmable high time, period and count.
// Start/stop control with done/err status; all outputs registered.
module pulse_train_gen #(
  parameter int TW = 8,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [TW-1:0] period,
  input  logic [TW-1:0] high_time,
  input  logic [CW-1:0] count,
  output logic          signal,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] pulses
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] per_r, per_n;
  logic [TW-1:0] hi_r, hi_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [TW-1:0] ph, ph_n;
  logic [CW-1:0] pulses_n;
  logic          done_n, err_n;
  logic          ok;

  assign ok = (period >= TW'(2)) && (high_time != '0) &&
              (high_time < period);

  // ph is the 1-based cycle position within the current period
  always_comb begin
    state_n  = state;
    per_n    = per_r;
    hi_n     = hi_r;
    cnt_n    = cnt_r;
    ph_n     = ph;
    pulses_n = pulses;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (ok) begin
            state_n  = HIGH;
            per_n    = period;
            hi_n     = high_time;
            cnt_n    = count;
            ph_n     = TW'(1);
            pulses_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          state_n = IDLE;
          ph_n    = '0;
        end else if (ph == hi_r) begin
          state_n  = LOW;
          pulses_n = pulses + CW'(1);
          ph_n     = ph + TW'(1);
        end else begin
          ph_n = ph + TW'(1);
        end
      end
      LOW: begin
        if (stop) begin
          state_n = IDLE;
          ph_n    = '0;
        end else if (ph == per_r) begin
          if ((cnt_r != '0) && (pulses == cnt_r)) begin
            state_n = IDLE;
            done_n  = 1'b1;
            ph_n    = '0;
          end else begin
            state_n = HIGH;
            ph_n    = TW'(1);
          end
        end else begin
          ph_n = ph + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        ph_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      per_r  <= '0;
      hi_r   <= '0;
      cnt_r  <= '0;
      ph     <= '0;
      pulses <= '0;
      signal <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      per_r  <= per_n;
      hi_r   <= hi_n;
      cnt_r  <= cnt_n;
      ph     <= ph_n;
      pulses <= pulses_n;
      signal <= (state_n == HIGH);
      busy   <= (state_n != IDLE);
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule
